// File: rtl/mips_muldiv_alu.sv
// MIPS EX-stage ALU: single-cycle logic/arith/shift/compare operations plus an
// iterative radix-2 multiply / restoring divide unit that owns HI and LO.
// A launch is registered for one cycle, then the FSM runs IDLE -> RUN -> FINISH.
module mips_muldiv_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [3:0]         AluOP,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               Start,
  output logic               Equal,
  output logic               Less,
  output logic [WIDTH-1:0]   Result,
  output logic [WIDTH-1:0]   Result_2,
  output logic               Busy,
  output logic               Done,
  output logic               DivByZero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_SLL   = 4'd0,
    OP_SRA   = 4'd1,
    OP_SRL   = 4'd2,
    OP_MULTU = 4'd3,
    OP_DIVU  = 4'd4,
    OP_ADD   = 4'd5,
    OP_SUB   = 4'd6,
    OP_AND   = 4'd7,
    OP_OR    = 4'd8,
    OP_XOR   = 4'd9,
    OP_NOR   = 4'd10,
    OP_SCMP  = 4'd11,
    OP_UCMP  = 4'd12,
    OP_MULT  = 4'd13,
    OP_DIV   = 4'd14,
    OP_RSVD  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  op_e    op;
  state_e state, state_next;

  // Registered launch request (raw operands and operation kind)
  logic               req_pend;
  logic               req_div;
  logic               req_sgn;
  logic [WIDTH-1:0]   req_x;
  logic [WIDTH-1:0]   req_y;

  // Iteration state
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dz;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH:0]   work;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;

  // Control from the output decoder
  logic               accept;
  logic               load;
  logic               step;
  logic               finish;

  // Datapath helpers
  logic               x_neg;
  logic               y_neg;
  logic [WIDTH-1:0]   x_mag;
  logic [WIDTH-1:0]   y_mag;
  logic [2*WIDTH:0]   work_load;
  logic [2*WIDTH:0]   work_step;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               is_muldiv;

  assign op        = op_e'(AluOP);
  assign is_muldiv = (op == OP_MULTU) || (op == OP_DIVU) || (op == OP_MULT) || (op == OP_DIV);

  // A new request is taken only when the unit is fully idle (no pending launch)
  assign accept = Start && is_muldiv && (state == S_IDLE) && !req_pend;

  // Flag outputs are pure functions of the operands
  always_comb begin
    Equal = (X == Y);
    Less  = ($signed(X) < $signed(Y));
  end

  // FSM state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (req_pend) state_next = S_RUN;
      S_RUN:    if (cnt == CNT_W'(WIDTH - 1)) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // FSM output decode: which datapath action happens at the next edge
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state)
      S_IDLE:   load   = req_pend;
      S_RUN:    step   = 1'b1;
      S_FINISH: finish = 1'b1;
      default:  ;
    endcase
  end

  // Launch request capture; operand changes after this edge are not seen
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req_pend <= 1'b0;
      req_div  <= 1'b0;
      req_sgn  <= 1'b0;
      req_x    <= '0;
      req_y    <= '0;
    end else if (accept) begin
      req_pend <= 1'b1;
      req_div  <= (op == OP_DIVU) || (op == OP_DIV);
      req_sgn  <= (op == OP_MULT) || (op == OP_DIV);
      req_x    <= X;
      req_y    <= Y;
    end else if (load) begin
      req_pend <= 1'b0;
    end
  end

  // Magnitudes of the latched operands; |MIN| is simply 2^(WIDTH-1) unsigned
  always_comb begin
    x_neg     = req_sgn & req_x[WIDTH-1];
    y_neg     = req_sgn & req_y[WIDTH-1];
    x_mag     = x_neg ? (-req_x) : req_x;
    y_mag     = y_neg ? (-req_y) : req_y;
    work_load = '0;
    work_load[WIDTH-1:0] = x_mag;
  end

  // One iteration: work holds {acc, multiplier} for multiply, {rem, quotient} for divide
  always_comb begin
    shifted = work << 1;
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, opb};
    mul_sum = work[2*WIDTH:WIDTH] + (work[0] ? {1'b0, opb} : '0);
    if (is_div) begin
      if (shifted[2*WIDTH:WIDTH] >= {1'b0, opb})
        work_step = {trial, shifted[WIDTH-1:1], 1'b1};
      else
        work_step = shifted;
    end else begin
      work_step = {1'b0, mul_sum, work[WIDTH-1:1]};
    end
  end

  // Sign fixup applied in FINISH
  always_comb begin
    prod_fix = neg_q ? (-work[2*WIDTH-1:0]) : work[2*WIDTH-1:0];
    quo_fix  = neg_q ? (-work[WIDTH-1:0]) : work[WIDTH-1:0];
    rem_fix  = neg_r ? (-work[2*WIDTH-1:WIDTH]) : work[2*WIDTH-1:WIDTH];
  end

  // Multiply/divide datapath, HI/LO and status registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      opb       <= '0;
      work      <= '0;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (accept) DivByZero <= 1'b0;
      if (load) begin
        is_div <= req_div;
        neg_q  <= x_neg ^ y_neg;
        neg_r  <= x_neg;
        dz     <= req_div && (req_y == '0);
        opb    <= y_mag;
        work   <= work_load;
        cnt    <= '0;
        Busy   <= 1'b1;
      end
      if (step) begin
        work <= work_step;
        cnt  <= cnt + 1'b1;
      end
      if (finish) begin
        // Divide by zero: the restoring loop leaves |X| as remainder, so the
        // remainder fixup already yields HI=X; only LO needs forcing.
        if (is_div) begin
          lo        <= dz ? '1 : quo_fix;
          hi        <= rem_fix;
          DivByZero <= dz;
        end else begin
          {hi, lo} <= prod_fix;
        end
        Done <= 1'b1;
        Busy <= 1'b0;
      end
    end
  end

  // Result multiplexer
  always_comb begin
    Result   = '0;
    Result_2 = '0;
    case (op)
      OP_SLL:   Result = Y << shamt;
      OP_SRA:   Result = $signed(Y) >>> shamt;
      OP_SRL:   Result = Y >> shamt;
      OP_ADD:   Result = X + Y;
      OP_SUB:   Result = X - Y;
      OP_AND:   Result = X & Y;
      OP_OR:    Result = X | Y;
      OP_XOR:   Result = X ^ Y;
      OP_NOR:   Result = ~(X | Y);
      OP_SCMP:  Result[0] = ($signed(X) < $signed(Y));
      OP_UCMP:  Result[0] = (X < Y);
      OP_MULTU, OP_DIVU, OP_MULT, OP_DIV: begin
        Result   = lo;
        Result_2 = hi;
      end
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_mips_muldiv_alu.sv
// Directed self-checking bench for mips_muldiv_alu (WIDTH=32 plus a WIDTH=16 copy).
module tb_mips_muldiv_alu;

  logic        CLK;
  logic        nRST;
  logic [3:0]  AluOP;
  logic [31:0] X, Y;
  logic [4:0]  shamt;
  logic        Start;
  logic        Equal, Less, Busy, Done, DivByZero;
  logic [31:0] Result, Result_2;

  logic [3:0]  op16;
  logic [15:0] x16, y16;
  logic [3:0]  sh16;
  logic        start16;
  logic        eq16, less16, busy16, done16, dz16;
  logic [15:0] res16, res2_16;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  mips_muldiv_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .AluOP(AluOP), .X(X), .Y(Y), .shamt(shamt),
    .Start(Start), .Equal(Equal), .Less(Less), .Result(Result),
    .Result_2(Result_2), .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  mips_muldiv_alu #(.WIDTH(16), .SHAMT_W(4)) dut16 (
    .CLK(CLK), .nRST(nRST), .AluOP(op16), .X(x16), .Y(y16), .shamt(sh16),
    .Start(start16), .Equal(eq16), .Less(less16), .Result(res16),
    .Result_2(res2_16), .Busy(busy16), .Done(done16), .DivByZero(dz16)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Launch on edge 0, scramble operands, return edge index of Done and Busy-high samples
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n);
    AluOP = op; X = a; Y = b; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0; X = ~a; Y = ~b;
    lat = -1;
    busy_n = Busy ? 1 : 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK); #1;
      if (Busy) busy_n++;
      if (Done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    nRST = 1'b0; AluOP = 4'd3; X = '0; Y = '0; shamt = '0; Start = 1'b0;
    op16 = 4'd3; x16 = '0; y16 = '0; sh16 = '0; start16 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (Busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", Busy); else passes++;
    checks++; if (Done !== 1'b0) $display("FAIL reset_done got=%b exp=0", Done); else passes++;
    checks++; if (DivByZero !== 1'b0) $display("FAIL reset_dz got=%b exp=0", DivByZero); else passes++;
    checks++; if (Result !== 32'h0) $display("FAIL reset_lo got=%h exp=0", Result); else passes++;
    checks++; if (Result_2 !== 32'h0) $display("FAIL reset_hi got=%h exp=0", Result_2); else passes++;
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_comb;
    vec_t v[15];
    v[0]  = {4'd1,  32'h0,         32'h8000_0000, 5'd0,  32'h8000_0000};
    v[1]  = {4'd1,  32'h0,         32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    v[2]  = {4'd1,  32'h0,         32'h7000_0000, 5'd4,  32'h0700_0000};
    v[3]  = {4'd0,  32'h0,         32'h8000_0001, 5'd1,  32'h0000_0002};
    v[4]  = {4'd2,  32'h0,         32'h8000_0000, 5'd31, 32'h0000_0001};
    v[5]  = {4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000};
    v[6]  = {4'd6,  32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF};
    v[7]  = {4'd7,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000};
    v[8]  = {4'd8,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hFFF0_FFF0};
    v[9]  = {4'd9,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h0FF0_0FF0};
    v[10] = {4'd10, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'h000F_000F};
    v[11] = {4'd11, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001};
    v[12] = {4'd12, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000};
    v[13] = {4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3,  32'h0000_0000};
    v[14] = {4'd2,  32'h0,         32'hF000_0000, 5'd0,  32'hF000_0000};
    for (int i = 0; i < 15; i++) begin
      AluOP = v[i].op; X = v[i].x; Y = v[i].y; shamt = v[i].sh;
      #1;
      checks++;
      if (Result !== v[i].exp)
        $display("FAIL comb_vec%0d op=%0d got=%h exp=%h", i, v[i].op, Result, v[i].exp);
      else passes++;
      checks++;
      if (Result_2 !== 32'h0)
        $display("FAIL comb_r2_vec%0d got=%h exp=0", i, Result_2);
      else passes++;
    end
    X = 32'hFFFF_FFFF; Y = 32'h0000_0001; #1;
    checks++; if (Less !== 1'b1) $display("FAIL less_neg got=%b exp=1", Less); else passes++;
    checks++; if (Equal !== 1'b0) $display("FAIL equal_ne got=%b exp=0", Equal); else passes++;
    X = 32'h5; Y = 32'h5; #1;
    checks++; if (Equal !== 1'b1) $display("FAIL equal_eq got=%b exp=1", Equal); else passes++;
    checks++; if (Less !== 1'b0) $display("FAIL less_eq got=%b exp=0", Less); else passes++;
  endtask

  task automatic test_multu;
    int lat, bn;
    run_op(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn);
    checks++; if (lat !== 34) $display("FAIL multu_latency got=%0d exp=34", lat); else passes++;
    checks++; if (bn !== 33) $display("FAIL multu_busy_cycles got=%0d exp=33", bn); else passes++;
    checks++; if (Result_2 !== 32'hFFFF_FFFE) $display("FAIL multu_hi got=%h exp=fffffffe", Result_2); else passes++;
    checks++; if (Result !== 32'h0000_0001) $display("FAIL multu_lo got=%h exp=00000001", Result); else passes++;
    @(posedge CLK); #1;
    checks++; if (Done !== 1'b0) $display("FAIL done_pulse_width got=%b exp=0", Done); else passes++;
    checks++; if (Busy !== 1'b0) $display("FAIL busy_after_done got=%b exp=0", Busy); else passes++;
  endtask

  task automatic test_mult_div_signed;
    int lat, bn;
    run_op(4'd13, 32'hFFFF_FFF9, 32'h0000_0003, lat, bn);
    checks++; if (Result_2 !== 32'hFFFF_FFFF) $display("FAIL mult_hi got=%h exp=ffffffff", Result_2); else passes++;
    checks++; if (Result !== 32'hFFFF_FFEB) $display("FAIL mult_lo got=%h exp=ffffffeb", Result); else passes++;
    run_op(4'd14, 32'hFFFF_FFF9, 32'h0000_0002, lat, bn);
    checks++; if (lat !== 34) $display("FAIL div_latency got=%0d exp=34", lat); else passes++;
    checks++; if (Result !== 32'hFFFF_FFFD) $display("FAIL div_lo got=%h exp=fffffffd", Result); else passes++;
    checks++; if (Result_2 !== 32'hFFFF_FFFF) $display("FAIL div_hi got=%h exp=ffffffff", Result_2); else passes++;
    run_op(4'd4, 32'd100, 32'd7, lat, bn);
    checks++; if (Result !== 32'd14) $display("FAIL divu_lo got=%h exp=0000000e", Result); else passes++;
    checks++; if (Result_2 !== 32'd2) $display("FAIL divu_hi got=%h exp=00000002", Result_2); else passes++;
    run_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn);
    checks++; if (Result !== 32'h8000_0000) $display("FAIL div_min_lo got=%h exp=80000000", Result); else passes++;
    checks++; if (Result_2 !== 32'h0) $display("FAIL div_min_hi got=%h exp=0", Result_2); else passes++;
    checks++; if (DivByZero !== 1'b0) $display("FAIL div_min_flag got=%b exp=0", DivByZero); else passes++;
  endtask

  task automatic test_div_by_zero;
    int lat, bn;
    run_op(4'd4, 32'd100, 32'd0, lat, bn);
    checks++; if (lat !== 34) $display("FAIL dz_latency got=%0d exp=34", lat); else passes++;
    checks++; if (Result !== 32'hFFFF_FFFF) $display("FAIL dz_lo got=%h exp=ffffffff", Result); else passes++;
    checks++; if (Result_2 !== 32'd100) $display("FAIL dz_hi got=%h exp=00000064", Result_2); else passes++;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (DivByZero !== 1'b1) $display("FAIL dz_sticky got=%b exp=1", DivByZero); else passes++;
    AluOP = 4'd4; X = 32'd10; Y = 32'd3; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    checks++; if (DivByZero !== 1'b0) $display("FAIL dz_clear got=%b exp=0", DivByZero); else passes++;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK); #1;
      if (Done) begin lat = n; break; end
    end
    checks++; if (lat !== 34) $display("FAIL dz_next_latency got=%0d exp=34", lat); else passes++;
    checks++; if (Result !== 32'd3) $display("FAIL dz_next_lo got=%h exp=00000003", Result); else passes++;
    checks++; if (Result_2 !== 32'd1) $display("FAIL dz_next_hi got=%h exp=00000001", Result_2); else passes++;
    run_op(4'd14, 32'hFFFF_FFFB, 32'd0, lat, bn);
    checks++; if (Result !== 32'hFFFF_FFFF) $display("FAIL sdz_lo got=%h exp=ffffffff", Result); else passes++;
    checks++; if (Result_2 !== 32'hFFFF_FFFB) $display("FAIL sdz_hi got=%h exp=fffffffb", Result_2); else passes++;
    checks++; if (DivByZero !== 1'b1) $display("FAIL sdz_flag got=%b exp=1", DivByZero); else passes++;
  endtask

  task automatic test_busy_ignore;
    int dones;
    int lat, bn;
    run_op(4'd3, 32'd6, 32'd7, lat, bn);
    AluOP = 4'd3; X = 32'd3; Y = 32'd5; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0; X = 32'd7; Y = 32'd7;
    dones = 0;
    repeat (5) begin @(posedge CLK); #1; if (Done) dones++; end
    checks++; if (Result !== 32'd42) $display("FAIL hold_lo_during_run got=%h exp=0000002a", Result); else passes++;
    Start = 1'b1;
    repeat (3) begin @(posedge CLK); #1; if (Done) dones++; end
    Start = 1'b0;
    for (int n = 0; n < 50; n++) begin @(posedge CLK); #1; if (Done) dones++; end
    checks++; if (dones !== 1) $display("FAIL ignore_done_count got=%0d exp=1", dones); else passes++;
    checks++; if (Result !== 32'd15) $display("FAIL ignore_lo got=%h exp=0000000f", Result); else passes++;
    checks++; if (Result_2 !== 32'd0) $display("FAIL ignore_hi got=%h exp=0", Result_2); else passes++;
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    run_op(4'd3, 32'd1000, 32'd1000, lat, bn);
    checks++; if (Done !== 1'b1) $display("FAIL b2b_first_done got=%b exp=1", Done); else passes++;
    run_op(4'd13, 32'hFFFF_FFFE, 32'hFFFF_FFFD, lat, bn);
    checks++; if (lat !== 34) $display("FAIL b2b_latency got=%0d exp=34", lat); else passes++;
    checks++; if (Result !== 32'd6) $display("FAIL b2b_lo got=%h exp=00000006", Result); else passes++;
    checks++; if (Result_2 !== 32'd0) $display("FAIL b2b_hi got=%h exp=0", Result_2); else passes++;
  endtask

  task automatic test_abort;
    int dones;
    AluOP = 4'd3; X = 32'd9; Y = 32'd9; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    checks++; if (Result !== 32'd6) $display("FAIL abort_prior_lo got=%h exp=00000006", Result); else passes++;
    nRST = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", Busy); else passes++;
    checks++; if (Result !== 32'h0) $display("FAIL abort_lo got=%h exp=0", Result); else passes++;
    checks++; if (Result_2 !== 32'h0) $display("FAIL abort_hi got=%h exp=0", Result_2); else passes++;
    @(posedge CLK); #1;
    nRST = 1'b1;
    dones = 0;
    for (int n = 0; n < 45; n++) begin @(posedge CLK); #1; if (Done || Busy) dones++; end
    checks++; if (dones !== 0) $display("FAIL abort_no_done got=%0d exp=0", dones); else passes++;
    checks++; if (Result !== 32'h0) $display("FAIL abort_lo_after got=%h exp=0", Result); else passes++;
  endtask

  task automatic test_width16;
    int lat;
    op16 = 4'd3; x16 = 16'hFFFF; y16 = 16'hFFFF; start16 = 1'b1;
    @(posedge CLK); #1;
    start16 = 1'b0; x16 = 16'h0; y16 = 16'h0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK); #1;
      if (done16) begin lat = n; break; end
    end
    checks++; if (lat !== 18) $display("FAIL w16_latency got=%0d exp=18", lat); else passes++;
    checks++; if (res2_16 !== 16'hFFFE) $display("FAIL w16_hi got=%h exp=fffe", res2_16); else passes++;
    checks++; if (res16 !== 16'h0001) $display("FAIL w16_lo got=%h exp=0001", res16); else passes++;
  endtask

  initial begin
    test_reset;
    test_comb;
    test_multu;
    test_mult_div_signed;
    test_div_by_zero;
    test_busy_ignore;
    test_back_to_back;
    test_abort;
    test_width16;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
